// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the three-client memory request arbiter.
package mem_arb_pkg;
  localparam int NCLIENTS   = 3;
  localparam int DEF_WIDTH  = 8;
  localparam int DEF_AW     = 4;
  localparam int TAG_STAGES = 2;

  typedef logic [1:0] cidx_t;

  typedef struct packed {
    logic  vld;
    logic  rd;
    cidx_t idx;
  } tag_t;

  // Client index k positions after p, wrapping over the client count.
  function automatic cidx_t rr_next(input cidx_t p, input int k);
    int s;
    s = (int'(p) + k) % NCLIENTS;
    return s[1:0];
  endfunction
endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin grant logic with the last-granted pointer register.
module rr_arbiter3
  import mem_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NCLIENTS-1:0] req_valid,
  output logic [NCLIENTS-1:0] grant,
  output logic                grant_vld,
  output cidx_t               grant_idx
);
  cidx_t ptr;
  cidx_t idx;

  // Walk from the farthest candidate to the nearest so the nearest valid wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    grant_idx = ptr;
    idx       = ptr;
    for (int k = NCLIENTS; k >= 1; k--) begin
      idx = rr_next(ptr, k);
      if (rst && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

  // Reset to the last client so client 0 has first priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           ptr <= cidx_t'(NCLIENTS - 1);
    else if (grant_vld) ptr <= grant_idx;
  end
endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates three clients onto one synchronous memory port and routes read data back.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NCLIENTS-1:0]       req_valid,
  output logic [NCLIENTS-1:0]       req_ready,
  input  logic [NCLIENTS-1:0]       req_we,
  input  logic [NCLIENTS*AW-1:0]    req_addr,
  input  logic [NCLIENTS*WIDTH-1:0] req_wdata,
  output logic [NCLIENTS-1:0]       rsp_valid,
  output logic [WIDTH-1:0]          rsp_data,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [AW-1:0]             mem_addr,
  output logic [WIDTH-1:0]          mem_wdata,
  input  logic [WIDTH-1:0]          mem_rdata
);
  logic [NCLIENTS-1:0][AW-1:0]    addr_v;
  logic [NCLIENTS-1:0][WIDTH-1:0] wdata_v;
  logic                           grant_vld;
  cidx_t                          grant_idx;
  tag_t                           tag_in;
  tag_t [TAG_STAGES:1]            tag_pipe;

  assign addr_v  = req_addr;
  assign wdata_v = req_wdata;

  rr_arbiter3 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .grant     (req_ready),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx)
  );

  // Address and data hold across idle cycles; only the enables drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= grant_vld;
      mem_we <= grant_vld & req_we[grant_idx];
      if (grant_vld) begin
        mem_addr  <= addr_v[grant_idx];
        mem_wdata <= wdata_v[grant_idx];
      end
    end
  end

  assign tag_in = '{vld: grant_vld, rd: ~req_we[grant_idx], idx: grant_idx};

  // Stage 1 lines up with the memory access, stage 2 with the returned data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tag_pipe <= '0;
    else      tag_pipe <= {tag_pipe[TAG_STAGES-1:1], tag_in};
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NCLIENTS; i++)
      rsp_valid[i] = tag_pipe[TAG_STAGES].vld && tag_pipe[TAG_STAGES].rd &&
                     (tag_pipe[TAG_STAGES].idx == cidx_t'(i));
  end

  assign rsp_data = mem_rdata;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a one-cycle-latency memory model.
module tb_mem_req_arbiter;
  localparam int W  = 8;
  localparam int AW = 4;
  localparam int NC = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NC-1:0]     req_valid = '0, req_ready, req_we = '0, rsp_valid;
  logic [NC*AW-1:0]  req_addr = '0;
  logic [NC*W-1:0]   req_wdata = '0;
  logic [W-1:0]      rsp_data, mem_wdata, mem_rdata;
  logic              mem_en, mem_we;
  logic [AW-1:0]     mem_addr;

  logic [W-1:0]      mem [16];
  logic              pl_en = 1'b0;
  logic [AW-1:0]     pl_addr = '0;
  logic [W-1:0]      pl_data = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(.WIDTH(W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  function automatic logic [W-1:0] init_val(input int a);
    return 8'h57 + 8'(a);
  endfunction

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [W-1:0] d);
    req_we[i]           = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*W +: W]  = d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_addr = 4'(a); pl_data = init_val(a);
    end
    @(negedge clk);
    pl_en = 1'b0;
    req_valid = 3'b111;
    #1;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_en got=%b%b exp=00", mem_en, mem_we); end
    checks++; if (mem_addr !== 4'h0 || mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_addr got=%h/%h exp=0/00", mem_addr, mem_wdata); end
    checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL reset_rsp got=%b exp=000", rsp_valid); end
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    req_valid = 3'b010; set_req(1, 1'b0, 4'd3, 8'h00);
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL single_ready got=%b exp=010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 4'd3) begin
      errors++; $display("FAIL single_issue got en=%b we=%b addr=%0d exp en=1 we=0 addr=3", mem_en, mem_we, mem_addr); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 3'b010 || rsp_data !== 8'h5A) begin
      errors++; $display("FAIL single_rsp got=%b/%h exp=010/5a", rsp_valid, rsp_data); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 3'b000 || mem_en !== 1'b0) begin
      errors++; $display("FAIL single_after got rsp=%b en=%b exp=000/0", rsp_valid, mem_en); end
  endtask

  task automatic test_contention();
    logic [2:0] exp_g [3];
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req_valid = 3'b111;
    for (int i = 0; i < NC; i++) set_req(i, 1'b0, 4'(i), 8'h00);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++; if (req_ready !== exp_g[k%3] || !$onehot(req_ready)) begin
        errors++; $display("FAIL contention_grant%0d got=%b exp=%b", k, req_ready, exp_g[k%3]); end
    end
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write_read();
    @(negedge clk);
    req_valid = 3'b001; set_req(0, 1'b1, 4'd7, 8'hA5);
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL wr_ready got=%b exp=001", req_ready); end
    @(negedge clk);
    req_valid = 3'b100; set_req(2, 1'b0, 4'd7, 8'h00);
    #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL rd_ready got=%b exp=100", req_ready); end
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 4'd7 || mem_wdata !== 8'hA5) begin
      errors++; $display("FAIL wr_issue got en=%b we=%b addr=%0d d=%h exp 1/1/7/a5", mem_en, mem_we, mem_addr, mem_wdata); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || rsp_valid !== 3'b000) begin
      errors++; $display("FAIL rd_issue got en=%b we=%b rsp=%b exp 1/0/000", mem_en, mem_we, rsp_valid); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 3'b100 || rsp_data !== 8'hA5) begin
      errors++; $display("FAIL wr_rd_rsp got=%b/%h exp=100/a5", rsp_valid, rsp_data); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    req_valid = 3'b010; set_req(1, 1'b0, 4'd5, 8'h00);
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL abort_ready got=%b exp=010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;
    #1;
    checks++; if (mem_en !== 1'b0 || rsp_valid !== 3'b000) begin
      errors++; $display("FAIL abort_clear got en=%b rsp=%b exp 0/000", mem_en, rsp_valid); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL abort_rsp got=%b exp=000", rsp_valid); end
    @(negedge clk);
    rst = 1'b1;
    req_valid = 3'b011; set_req(0, 1'b0, 4'd0, 8'h00);
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL abort_first got=%b exp=001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL abort_late got=%b exp=000", rsp_valid); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 3'b001 || rsp_data !== 8'h57) begin
      errors++; $display("FAIL abort_post_rsp got=%b/%h exp=001/57", rsp_valid, rsp_data); end
    @(negedge clk);
  endtask

  task automatic test_streaming();
    int pulses = 0;
    logic [W-1:0] exp_d;
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      if (k < 16) begin req_valid = 3'b100; set_req(2, 1'b0, 4'(k), 8'h00); end
      else req_valid = '0;
      #1;
      if (k < 16) begin
        checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL stream_ready%0d got=%b exp=100", k, req_ready); end
      end
      if (k >= 2 && k < 18) begin
        exp_d = (k - 2 == 7) ? 8'hA5 : init_val(k - 2);
        if (rsp_valid === 3'b100) pulses++;
        checks++; if (rsp_valid !== 3'b100 || rsp_data !== exp_d) begin
          errors++; $display("FAIL stream_rsp%0d got=%b/%h exp=100/%h", k - 2, rsp_valid, rsp_data, exp_d); end
      end
      if (k == 18) begin
        checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL stream_tail got=%b exp=000", rsp_valid); end
      end
    end
    checks++; if (pulses != 16) begin errors++; $display("FAIL stream_count got=%0d exp=16", pulses); end
  endtask

  task automatic test_fairness();
    logic [2:0] vin  [12] = '{3'b011, 3'b111, 3'b011, 3'b111, 3'b000, 3'b111,
                              3'b011, 3'b111, 3'b000, 3'b011, 3'b111, 3'b011};
    logic [2:0] gexp [12] = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b000, 3'b100,
                              3'b001, 3'b010, 3'b000, 3'b001, 3'b010, 3'b001};
    logic       eexp [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                              1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int wait_c [3] = '{0, 0, 0};
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      req_valid = vin[k];
      #1;
      checks++; if (req_ready !== gexp[k]) begin errors++; $display("FAIL fair_grant%0d got=%b exp=%b", k, req_ready, gexp[k]); end
      checks++; if (mem_en !== eexp[k]) begin errors++; $display("FAIL fair_mem_en%0d got=%b exp=%b", k, mem_en, eexp[k]); end
      for (int i = 0; i < NC; i++) begin
        if (vin[k][i] && !req_ready[i]) wait_c[i]++;
        else wait_c[i] = 0;
        checks++; if (wait_c[i] > 2) begin errors++; $display("FAIL fair_wait c%0d cyc%0d got=%0d exp<=2", i, k, wait_c[i]); end
      end
    end
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write_read();
    test_reset_abort();
    test_streaming();
    test_fairness();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits.
REQ-002 Parameter AW, default 4: memory address width in bits; the memory holds 2**AW words.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  3  per-client request valid; bit i belongs to client i.
REQ-006 req_ready  output  3  per-client accept, one-hot or zero.
REQ-007 req_we  input  3  per-client write flag: 1 = write, 0 = read.
REQ-008 req_addr  input  3*AW  per-client address; client i uses slice [i*AW +: AW].
REQ-009 req_wdata  input  3*WIDTH  per-client write data; client i uses slice [i*WIDTH +: WIDTH].
REQ-010 rsp_valid  output  3  per-client read-response strobe.
REQ-011 rsp_data  output  WIDTH  read data; shared by all clients, qualified by rsp_valid.
REQ-012 mem_en  output  1  memory access enable.
REQ-013 mem_we  output  1  memory write enable.
REQ-014 mem_addr  output  AW  memory address.
REQ-015 mem_wdata  output  WIDTH  memory write data.
REQ-016 mem_rdata  input  WIDTH  memory read data, valid one cycle after a read is presented.

Function
REQ-017 Acceptance: a request from client i is accepted in a cycle when req_valid[i] and req_ready[i] are both high; at most one request is accepted per cycle.
REQ-018 Readiness: req_ready is combinational from req_valid and the round-robin pointer; req_ready[i] never goes high unless req_valid[i] is high.
REQ-019 Round-robin order: the search starts at client (ptr+1) mod 3 and wraps; after each grant, ptr is set to the granted index; ptr does not change in a cycle with no grant.
REQ-020 Fairness: a client holding req_valid high continuously is granted within 3 cycles.
REQ-021 Issue timing: a request accepted in cycle N drives the memory in cycle N+1 from registered outputs: mem_en=1, mem_we=req_we[i], mem_addr and mem_wdata captured from client i.
REQ-022 Idle memory port: in a cycle with no issued request, mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their previous values.
REQ-023 Read response: a read accepted in cycle N asserts rsp_valid[i] for exactly one cycle, in cycle N+2, with rsp_data equal to mem_rdata in that cycle.
REQ-024 Write response: an accepted write produces no response.
REQ-025 Response back-pressure: there is none; back-to-back reads from any clients yield one rsp_valid pulse per cycle, in acceptance order.
REQ-026 Ordering: requests reach the memory in acceptance order, so a read accepted after a write to the same address returns the written data.
REQ-027 Pipeline tag: a 2-stage tag pipeline (valid, read flag, client index) follows each request, and rsp_valid is decoded from stage 2.
REQ-028 Address range: all 2**AW addresses are legal; there is no out-of-range case.

Reset
REQ-029 While rst=0: ptr=2 (so client 0 wins first), mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, tag pipeline cleared, rsp_valid=0, req_ready=0.
REQ-030 Reset mid-operation: all in-flight reads are discarded and no rsp_valid fires for them.
REQ-031 Release: the first grant is possible in the first clk edge after rst deasserts.

Structure
REQ-032 Package mem_arb_pkg holds NCLIENTS=3, the default WIDTH and AW values, and the client-index typedef (2 bits).
REQ-033 Sub-module rr_arbiter3 holds the combinational grant logic and the pointer register; the top level holds the memory issue registers and the tag pipeline.

Verification
REQ-034 Single read: release reset; memory preloaded with 0x5A at address 3; client 1 reads address 3 in cycle N -> mem_en=1, mem_addr=3 in N+1; rsp_valid=3'b010, rsp_data=0x5A in N+2.
REQ-035 Contention: all three clients hold valid from the first cycle after reset -> grants in order 0,1,2,0,1,2; req_ready is one-hot every cycle.
REQ-036 Write then read: client 0 writes 0xA5 to address 7, and client 2's read of address 7 is accepted next -> client 2 receives rsp_data=0xA5 with rsp_valid=3'b100.
REQ-037 Reset abort: assert rst in the cycle after accepting a read -> no rsp_valid pulse follows, and the first grant after release goes to client 0.
REQ-038 Streaming: client 2 issues reads of addresses 0..15 back-to-back -> 16 consecutive rsp_valid pulses with data matching the memory contents in address order.
REQ-039 Idle/fairness: clients 0 and 1 request continuously while client 2 toggles req_valid -> no client waits more than 3 cycles, and mem_en=0 in every cycle that follows a cycle with no grant.
